// File: rtl/controle_leitura_andar_pkg.sv
// Shared definitions for the floor-reading scheduler: FSM state codes and floor width.
package controle_leitura_andar_pkg;

    localparam int ANDAR_W = 2;
    // Confirmation and failure counts both span 1..15.
    localparam int CONT_W  = 4;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        ESPERA  = 3'd1,
        DISPARA = 3'd2,
        AGUARDA = 3'd3,
        AVALIA  = 3'd4
    } estado_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/controle_leitura_andar_contador_m.sv
// Modulo counter: counts while enabled and wraps to zero on the cycle it sits at fim_valor.
module contador_m #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] fim_valor,
    output logic         fim
);

    logic [W-1:0] cnt_q, cnt_d;

    assign fim = en && (cnt_q == fim_valor);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || fim)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/controle_leitura_andar.sv
// Periodic measurement scheduler with pronto timeout and N-reading floor debounce.
module controle_leitura_andar
    import controle_leitura_andar_pkg::*;
#(
    parameter int PERIODO    = 5000000,
    parameter int TIMEOUT    = 2500000,
    parameter int N_CONFIRMA = 3,
    parameter int MAX_FALHAS = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               habilitar,
    input  logic               pronto,
    input  logic [ANDAR_W-1:0] andar_medido,
    output logic               medir,
    output logic [ANDAR_W-1:0] andar_atual,
    output logic               andar_valido,
    output logic               mudou_andar,
    output logic               subindo,
    output logic               descendo,
    output logic               erro_sensor,
    output logic [3:0]         db_estado
);

    localparam int CNT_MAX = max_int(PERIODO, TIMEOUT);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0]  FIM_PERIODO = CNT_W'(PERIODO - 1);
    localparam logic [CNT_W-1:0]  FIM_TIMEOUT = CNT_W'(TIMEOUT - 1);
    localparam logic [CONT_W-1:0] CONF_N      = CONT_W'(N_CONFIRMA);
    localparam logic [CONT_W-1:0] FALHAS_N    = CONT_W'(MAX_FALHAS);

    estado_t              estado_q, estado_d;
    logic                 medir_q, medir_d;
    logic [ANDAR_W-1:0]   andar_q, andar_d;
    logic                 valido_q, valido_d;
    logic                 mudou_q, mudou_d;
    logic                 sub_q, sub_d;
    logic                 desc_q, desc_d;
    logic                 erro_q, erro_d;
    logic [ANDAR_W-1:0]   cap_q, cap_d;
    logic [ANDAR_W-1:0]   cand_q, cand_d;
    logic [CONT_W-1:0]    conf_q, conf_d;
    logic [CONT_W-1:0]    falhas_q, falhas_d;

    logic                 cnt_en, cnt_clr, cnt_fim;
    logic [CNT_W-1:0]     cnt_fim_valor;
    logic [ANDAR_W-1:0]   cand_nx;
    logic [CONT_W-1:0]    conf_nx, falhas_inc;
    logic                 aceita;

    // One counter serves both the inter-measurement gap and the pronto timeout.
    assign cnt_en        = habilitar && (estado_q == ESPERA || estado_q == AGUARDA);
    assign cnt_clr       = !cnt_en || (estado_q == AGUARDA && pronto);
    assign cnt_fim_valor = (estado_q == ESPERA) ? FIM_PERIODO : FIM_TIMEOUT;

    contador_m #(.W(CNT_W)) u_contador (
        .clock     (clock),
        .reset     (reset),
        .clr       (cnt_clr),
        .en        (cnt_en),
        .fim_valor (cnt_fim_valor),
        .fim       (cnt_fim)
    );

    always_comb begin
        if (cap_q == cand_q && conf_q != '0) begin
            cand_nx = cand_q;
            conf_nx = (conf_q >= CONF_N) ? CONF_N : conf_q + 1'b1;
        end else begin
            cand_nx = cap_q;
            conf_nx = CONT_W'(1);
        end
        aceita     = (conf_nx == CONF_N) && (!valido_q || cand_nx != andar_q);
        falhas_inc = (falhas_q == '1) ? falhas_q : falhas_q + 1'b1;
    end

    always_comb begin
        estado_d = estado_q;
        medir_d  = 1'b0;
        mudou_d  = 1'b0;
        andar_d  = andar_q;
        valido_d = valido_q;
        sub_d    = sub_q;
        desc_d   = desc_q;
        erro_d   = erro_q;
        cap_d    = cap_q;
        cand_d   = cand_q;
        conf_d   = conf_q;
        falhas_d = falhas_q;
        if (!habilitar) begin
            estado_d = OCIOSO;
            cand_d   = '0;
            conf_d   = '0;
        end else begin
            case (estado_q)
                OCIOSO: estado_d = ESPERA;
                ESPERA: if (cnt_fim) begin
                    estado_d = DISPARA;
                    medir_d  = 1'b1;
                end
                DISPARA: estado_d = AGUARDA;
                AGUARDA: begin
                    // A pronto on the timeout cycle still counts as a reading.
                    if (pronto) begin
                        cap_d    = andar_medido;
                        falhas_d = '0;
                        erro_d   = 1'b0;
                        estado_d = AVALIA;
                    end else if (cnt_fim) begin
                        falhas_d = falhas_inc;
                        if (falhas_inc >= FALHAS_N)
                            erro_d = 1'b1;
                        estado_d = ESPERA;
                    end
                end
                AVALIA: begin
                    cand_d   = cand_nx;
                    conf_d   = conf_nx;
                    estado_d = ESPERA;
                    if (aceita) begin
                        andar_d  = cand_nx;
                        valido_d = 1'b1;
                        mudou_d  = 1'b1;
                        sub_d    = valido_q && (cand_nx > andar_q);
                        desc_d   = valido_q && (cand_nx < andar_q);
                    end
                end
                default: estado_d = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
            medir_q  <= 1'b0;
            andar_q  <= '0;
            valido_q <= 1'b0;
            mudou_q  <= 1'b0;
            sub_q    <= 1'b0;
            desc_q   <= 1'b0;
            erro_q   <= 1'b0;
            cap_q    <= '0;
            cand_q   <= '0;
            conf_q   <= '0;
            falhas_q <= '0;
        end else begin
            estado_q <= estado_d;
            medir_q  <= medir_d;
            andar_q  <= andar_d;
            valido_q <= valido_d;
            mudou_q  <= mudou_d;
            sub_q    <= sub_d;
            desc_q   <= desc_d;
            erro_q   <= erro_d;
            cap_q    <= cap_d;
            cand_q   <= cand_d;
            conf_q   <= conf_d;
            falhas_q <= falhas_d;
        end
    end

    assign medir        = medir_q;
    assign andar_atual  = andar_q;
    assign andar_valido = valido_q;
    assign mudou_andar  = mudou_q;
    assign subindo      = sub_q;
    assign descendo     = desc_q;
    assign erro_sensor  = erro_q;
    assign db_estado    = {1'b0, estado_q};

endmodule

// File: tb/tb_controle_leitura_andar.sv
// Directed bench for controle_leitura_andar: timestamp-based schedule/debounce model plus literal checks.
module tb_controle_leitura_andar;

    localparam int PERIODO    = 10;
    localparam int TIMEOUT    = 8;
    localparam int N_CONFIRMA = 3;
    localparam int MAX_FALHAS = 3;

    logic       clock = 0;
    logic       reset = 1;
    logic       habilitar = 0;
    logic       pronto = 0;
    logic [1:0] andar_medido = 0;
    logic       medir, andar_valido, mudou_andar, subindo, descendo, erro_sensor;
    logic [1:0] andar_atual;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;

    controle_leitura_andar #(
        .PERIODO(PERIODO), .TIMEOUT(TIMEOUT),
        .N_CONFIRMA(N_CONFIRMA), .MAX_FALHAS(MAX_FALHAS)
    ) dut (
        .clock(clock), .reset(reset), .habilitar(habilitar), .pronto(pronto),
        .andar_medido(andar_medido), .medir(medir), .andar_atual(andar_atual),
        .andar_valido(andar_valido), .mudou_andar(mudou_andar), .subindo(subindo),
        .descendo(descendo), .erro_sensor(erro_sensor), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nome, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nome, got, exp, $time);
        end
    endtask

    // Model: phase derived from absolute cycle stamps of the next medir and the last request.
    int  cyc, fase, medir_at, ult_medir, falhas, leitura;
    int  hist[$];
    bit  run_ok;
    int  e_medir, e_atual, e_valido, e_mudou, e_sub, e_desc, e_erro;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc = 0; fase = 0; medir_at = 0; ult_medir = 0; falhas = 0; leitura = 0;
            hist.delete();
            e_medir = 0; e_atual = 0; e_valido = 0; e_mudou = 0;
            e_sub = 0; e_desc = 0; e_erro = 0;
        end else begin
            e_mudou = 0;
            if (!habilitar) begin
                fase = 0;
                hist.delete();
            end else begin
                case (fase)
                    0: begin fase = 1; medir_at = cyc + 1 + PERIODO; end
                    1: if (cyc + 1 == medir_at) fase = 2;
                    2: begin fase = 3; ult_medir = cyc; end
                    3: if (pronto) begin
                        leitura = int'(andar_medido);
                        falhas = 0; e_erro = 0; fase = 4;
                        medir_at = cyc + 2 + PERIODO;
                    end else if (cyc == ult_medir + TIMEOUT) begin
                        if (falhas < 15) falhas++;
                        if (falhas >= MAX_FALHAS) e_erro = 1;
                        fase = 1;
                        medir_at = cyc + 1 + PERIODO;
                    end
                    4: begin
                        hist.push_back(leitura);
                        if (hist.size() > N_CONFIRMA) void'(hist.pop_front());
                        run_ok = (hist.size() == N_CONFIRMA);
                        foreach (hist[i]) if (hist[i] != leitura) run_ok = 0;
                        if (run_ok && (e_valido == 0 || leitura != e_atual)) begin
                            e_sub    = (e_valido != 0 && leitura > e_atual) ? 1 : 0;
                            e_desc   = (e_valido != 0 && leitura < e_atual) ? 1 : 0;
                            e_atual  = leitura;
                            e_valido = 1;
                            e_mudou  = 1;
                        end
                        fase = 1;
                    end
                    default: fase = 0;
                endcase
            end
            e_medir = (fase == 2) ? 1 : 0;
            cyc++;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            chk("m_medir",  int'(medir),        e_medir);
            chk("m_atual",  int'(andar_atual),  e_atual);
            chk("m_valido", int'(andar_valido), e_valido);
            chk("m_mudou",  int'(mudou_andar),  e_mudou);
            chk("m_sub",    int'(subindo),      e_sub);
            chk("m_desc",   int'(descendo),     e_desc);
            chk("m_erro",   int'(erro_sensor),  e_erro);
            chk("m_estado", int'(db_estado),    fase);
        end
    end

    task automatic esperar_medir(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!medir && n < 200);
        if (!medir) begin
            checks++; errors++;
            $display("FAIL esperar_medir no medir within %0d cycles", n);
        end
    endtask

    // Answers the next request k cycles after medir; returns one cycle after the pronto cycle.
    task automatic responder(input int k, input logic [1:0] a);
        int n;
        esperar_medir(n);
        repeat (k) @(negedge clock);
        pronto = 1; andar_medido = a;
        @(negedge clock);
        pronto = 0;
    endtask

    task automatic chk_zero(input string nome);
        chk({nome, "_medir"},  int'(medir), 0);
        chk({nome, "_atual"},  int'(andar_atual), 0);
        chk({nome, "_valido"}, int'(andar_valido), 0);
        chk({nome, "_mudou"},  int'(mudou_andar), 0);
        chk({nome, "_sub"},    int'(subindo), 0);
        chk({nome, "_desc"},   int'(descendo), 0);
        chk({nome, "_erro"},   int'(erro_sensor), 0);
        chk({nome, "_estado"}, int'(db_estado), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0] seq3 [5];
        seq3 = '{2'd3, 2'd3, 2'd1, 2'd3, 2'd3};

        #1 reset = 0;
        #1 chk_zero("reset");
        @(negedge clock); @(negedge clock);
        reset = 1;

        // 1: first medir 11 cycles after habilitar, then a 19-cycle unanswered period
        @(negedge clock);
        habilitar = 1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            if (i == 1)  chk("t1_estado_espera", int'(db_estado), 1);
            if (i < 11)  chk("t1_medir_low", int'(medir), 0);
            if (i == 11) begin
                chk("t1_medir_11", int'(medir), 1);
                chk("t1_estado_dispara", int'(db_estado), 2);
            end
            if (i == 12) begin
                chk("t1_medir_pulse", int'(medir), 0);
                chk("t1_estado_aguarda", int'(db_estado), 3);
            end
        end
        esperar_medir(n);
        chk("t1_period", n, 18);

        // 2: three readings of floor 2 confirm it
        responder(3, 2'd2);
        responder(5, 2'd2);
        @(negedge clock);
        chk("t2_not_yet", int'(andar_valido), 0);
        responder(2, 2'd2);
        @(negedge clock);
        chk("t2_mudou", int'(mudou_andar), 1);
        chk("t2_atual", int'(andar_atual), 2);
        chk("t2_valido", int'(andar_valido), 1);
        chk("t2_sub", int'(subindo), 0);
        chk("t2_desc", int'(descendo), 0);
        @(negedge clock);
        pronto = 1; andar_medido = 2'd1;  // stray pronto while waiting out the period
        @(negedge clock);
        pronto = 0;

        // 3: 3,3,1,3,3 then 3 -> only the last reading moves to floor 3
        for (int i = 0; i < 5; i++) responder(1, seq3[i]);
        @(negedge clock);
        chk("t3_hold", int'(andar_atual), 2);
        responder(4, 2'd3);
        @(negedge clock);
        chk("t3_mudou", int'(mudou_andar), 1);
        chk("t3_atual", int'(andar_atual), 3);
        chk("t3_sub", int'(subindo), 1);
        chk("t3_desc", int'(descendo), 0);
        @(negedge clock);
        chk("t3_mudou_once", int'(mudou_andar), 0);

        // 4: three timeouts raise erro_sensor; next pronto clears it
        esperar_medir(n);
        esperar_medir(n);
        esperar_medir(n);
        repeat (8) @(negedge clock);
        chk("t4_erro_before", int'(erro_sensor), 0);
        @(negedge clock);
        chk("t4_erro", int'(erro_sensor), 1);
        chk("t4_atual", int'(andar_atual), 3);
        responder(2, 2'd3);
        chk("t4_erro_clr", int'(erro_sensor), 0);
        chk("t4_atual_keep", int'(andar_atual), 3);

        // 5: pronto on the timeout cycle is a reading, not a third failure
        esperar_medir(n);
        esperar_medir(n);
        responder(8, 2'd0);
        chk("t5_no_erro", int'(erro_sensor), 0);
        responder(8, 2'd0);
        responder(8, 2'd0);
        @(negedge clock);
        chk("t5_mudou", int'(mudou_andar), 1);
        chk("t5_atual", int'(andar_atual), 0);
        chk("t5_desc", int'(descendo), 1);
        chk("t5_sub", int'(subindo), 0);

        // 6: drop habilitar in AGUARDA, then async reset in ESPERA
        esperar_medir(n);
        @(negedge clock);
        habilitar = 0;
        @(negedge clock);
        chk("t6_ocioso", int'(db_estado), 0);
        chk("t6_medir", int'(medir), 0);
        chk("t6_valido_held", int'(andar_valido), 1);
        chk("t6_desc_held", int'(descendo), 1);
        habilitar = 1;
        repeat (3) @(negedge clock);
        chk("t6_espera", int'(db_estado), 1);
        #2 reset = 0;
        #1 chk_zero("t6_reset");
        @(negedge clock);
        habilitar = 0;
        reset = 1;
        repeat (3) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
